// File: rtl/trace_event_monitor.sv
// trace_event_monitor
//   Watches the decoded retire trace of NUM_CORES cores, keeps a shadow copy of r3 per core
//   and turns OpenRISC l.nop simulation-control instructions (exit/report/putc) into events.
//   Events are queued per core and presented one at a time on a round-robin valid/ready port.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   trace_enable        per-core retire strobe
//   trace_insn          retired instruction, core i at [32i+31:32i]
//   trace_wben          writeback enable
//   trace_wbreg         writeback register index, core i at [5i+4:5i]
//   trace_wbdata        writeback data, core i at [32i+31:32i]
//   evt_valid/ready     event handshake
//   evt_core/code/value source core, l.nop immediate, shadow r3 at retire
//   core_done/all_done  sticky exit seen per core / on every core
//   overflow            sticky per-core queue drop flag
//   drop_count          saturating count of dropped events
//   clr_stat            synchronous clear of overflow and drop_count
module trace_event_monitor #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NUM_CORES-1:0]                                  trace_enable,
  input  logic [32*NUM_CORES-1:0]                               trace_insn,
  input  logic [NUM_CORES-1:0]                                  trace_wben,
  input  logic [5*NUM_CORES-1:0]                                trace_wbreg,
  input  logic [32*NUM_CORES-1:0]                               trace_wbdata,
  output logic                                                  evt_valid,
  input  logic                                                  evt_ready,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0]  evt_core,
  output logic [15:0]                                           evt_code,
  output logic [31:0]                                           evt_value,
  output logic [NUM_CORES-1:0]                                  core_done,
  output logic                                                  all_done,
  output logic [NUM_CORES-1:0]                                  overflow,
  output logic [CNT_WIDTH-1:0]                                  drop_count,
  input  logic                                                  clr_stat
);

  localparam int unsigned CoreW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned SumW  = CNT_WIDTH + 6;

  typedef logic [47:0] entry_t;  // {code[15:0], value[31:0]}

  logic [31:0]          r3_q     [NUM_CORES];
  logic [31:0]          r3_d     [NUM_CORES];
  entry_t               mem_q    [NUM_CORES][FIFO_DEPTH];
  entry_t               mem_d    [NUM_CORES][FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q [NUM_CORES];
  logic [PtrW-1:0]      wr_ptr_d [NUM_CORES];
  logic [PtrW-1:0]      rd_ptr_q [NUM_CORES];
  logic [PtrW-1:0]      rd_ptr_d [NUM_CORES];
  logic [CntW-1:0]      cnt_q    [NUM_CORES];
  logic [CntW-1:0]      cnt_d    [NUM_CORES];

  logic                 evt_valid_q, evt_valid_d;
  logic [CoreW-1:0]     evt_core_q, evt_core_d;
  logic [15:0]          evt_code_q, evt_code_d;
  logic [31:0]          evt_value_q, evt_value_d;
  logic [CoreW-1:0]     rr_q, rr_d;
  logic [NUM_CORES-1:0] core_done_q, core_done_d;
  logic [NUM_CORES-1:0] overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic                 load;
  logic                 grant_valid;
  logic [CoreW-1:0]     grant_idx;
  logic [NUM_CORES-1:0] nonempty;
  logic [NUM_CORES-1:0] pop;
  logic [NUM_CORES-1:0] drop;
  logic                 unused_insn_bits;

  // The output register may take a new event when it is empty or being accepted.
  assign load = ~evt_valid_q | evt_ready;

  // Round-robin: lowest nonempty index at/after the pointer, else lowest overall (wrap).
  always_comb begin
    logic             hi_found;
    logic [CoreW-1:0] hi_idx;
    logic [CoreW-1:0] lo_idx;
    hi_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (nonempty[i]) begin
        grant_valid = 1'b1;
        lo_idx      = CoreW'(i);
        if (CoreW'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = CoreW'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // Per-core decode, shadow r3 and queue bookkeeping.
  always_comb begin
    logic [31:0] insn;
    logic [15:0] imm;
    logic        detect;
    logic        full;
    logic        push;
    r3_d             = r3_q;
    mem_d            = mem_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    cnt_d            = cnt_q;
    core_done_d      = core_done_q;
    pop              = '0;
    drop             = '0;
    insn             = '0;
    imm              = '0;
    detect           = 1'b0;
    full             = 1'b0;
    push             = 1'b0;
    unused_insn_bits = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      insn             = trace_insn[32*i +: 32];
      imm              = insn[15:0];
      unused_insn_bits = unused_insn_bits ^ (^insn[23:16]);
      detect           = trace_enable[i] && (insn[31:24] == 8'h15) &&
                         (imm == 16'h0001 || imm == 16'h0002 || imm == 16'h0004);
      pop[i]           = load && grant_valid && (grant_idx == CoreW'(i));
      full             = (cnt_q[i] == CntW'(FIFO_DEPTH));
      // A same-cycle pop frees the slot, so a full queue still accepts.
      push             = detect && (!full || pop[i]);
      drop[i]          = detect && full && !pop[i];
      if (push) begin
        mem_d[i][wr_ptr_q[i]] = {imm, r3_q[i]};
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      cnt_d[i] = cnt_q[i] + CntW'(push) - CntW'(pop[i]);
      if (detect && imm == 16'h0001) begin
        core_done_d[i] = 1'b1;
      end
      // Event above captured the pre-update r3.
      if (trace_enable[i] && trace_wben[i] && trace_wbreg[5*i +: 5] == 5'd3) begin
        r3_d[i] = trace_wbdata[32*i +: 32];
      end
    end
  end

  // Output register, pointer advance and drop statistics.
  always_comb begin
    logic [4:0]      n_drop;
    logic [SumW-1:0] sum;
    evt_valid_d = evt_valid_q;
    evt_core_d  = evt_core_q;
    evt_code_d  = evt_code_q;
    evt_value_d = evt_value_q;
    rr_d        = rr_q;
    if (load) begin
      evt_valid_d = grant_valid;
      if (grant_valid) begin
        {evt_code_d, evt_value_d} = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        evt_core_d                = grant_idx;
        rr_d = (32'(grant_idx) + 32'd1 >= NUM_CORES) ? '0 : grant_idx + 1'b1;
      end
    end
    n_drop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      n_drop = n_drop + 5'(drop[i]);
    end
    sum = SumW'(drop_count_q) + SumW'(n_drop);
    if (clr_stat) begin
      overflow_d   = '0;
      drop_count_d = '0;
    end else begin
      overflow_d   = overflow_q | drop;
      drop_count_d = (|sum[SumW-1:CNT_WIDTH]) ? '1 : sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r3_q[i]     <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
      evt_valid_q  <= 1'b0;
      evt_core_q   <= '0;
      evt_code_q   <= '0;
      evt_value_q  <= '0;
      rr_q         <= '0;
      core_done_q  <= '0;
      overflow_q   <= '0;
      drop_count_q <= '0;
    end else begin
      r3_q         <= r3_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      evt_valid_q  <= evt_valid_d;
      evt_core_q   <= evt_core_d;
      evt_code_q   <= evt_code_d;
      evt_value_q  <= evt_value_d;
      rr_q         <= rr_d;
      core_done_q  <= core_done_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_core   = evt_core_q;
  assign evt_code   = evt_code_q;
  assign evt_value  = evt_value_q;
  assign core_done  = core_done_q;
  assign all_done   = &core_done_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/trace_event_monitor.md
Name: trace_event_monitor

Overview:
- Parametrised, synthesizable successor of the per-core trace decode and r3 shadow logic in the simulation benches.
- Sits beside the compute tiles and takes the decoded execution-trace fields of NUM_CORES cores.
- Keeps a shadow r3 per core and detects OpenRISC l.nop simulation-control instructions: exit, report and putc.
- Queues the detected events per core and delivers them one at a time through a round-robin valid/ready output, with drop accounting and all-cores-done detection.

Parameters:
- NUM_CORES, 4: number of monitored cores (1..16).
- FIFO_DEPTH, 4: event entries per core queue (power of two, >=2).
- CNT_WIDTH, 16: width of the dropped-event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- trace_enable  in  NUM_CORES  per-core retire strobe.
- trace_insn  in  32*NUM_CORES  retired instruction; core i at [32i+31:32i].
- trace_wben  in  NUM_CORES  writeback enable.
- trace_wbreg  in  5*NUM_CORES  writeback register index.
- trace_wbdata  in  32*NUM_CORES  writeback data.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_core  out  $clog2(NUM_CORES) (min 1)  source core of the event.
- evt_code  out  16  l.nop immediate: 0x0001 exit, 0x0002 report, 0x0004 putc.
- evt_value  out  32  shadow r3 of the source core when the nop retired.
- core_done  out  NUM_CORES  sticky: the core has retired an exit nop.
- all_done  out  1  &core_done.
- overflow  out  NUM_CORES  sticky: the core's queue dropped an event.
- drop_count  out  CNT_WIDTH  total dropped events, saturating.
- clr_stat  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (async, rst=1): all outputs are 0, shadow r3 registers are 0, queues are empty, and the round-robin pointer is 0.
- Shadow r3: a posedge with trace_enable[i] & trace_wben[i] & (wbreg==3) loads wbdata into r3[i]. When trace_enable[i]=0, no field of core i is sampled.
- Event detect: trace_enable[i] & insn[31:24]==8'h15 & insn[15:0] in {1,2,4}. Other immediates are ignored.
- The event value is r3[i] before any update in that same cycle. An l.nop does not write back, so there is no conflict.
- Push: on the detect edge the entry {code, value} is written into queue i.
- Full queue (count==FIFO_DEPTH):
  - If the arbiter pops queue i in the same cycle, the push still succeeds.
  - Otherwise the event is dropped, overflow[i] is set, and drop_count increments, saturating at all-ones.
- Done: core_done[i] sets on detection of code 1 even if that event is dropped. It stays set until reset; clr_stat does not clear it.
- Output register: loads when empty or when evt_valid & evt_ready (back-to-back transfers, one per cycle).
  - Arbiter picks the first nonempty queue starting at the pointer, wrapping around. After a grant the pointer becomes granted+1 mod NUM_CORES.
  - No grant when no queue is nonempty; evt_valid then drops after the handshake.
- Handshake rules: while evt_valid & !evt_ready, evt_core, evt_code and evt_value are held stable. Once asserted, evt_valid is never withdrawn without acceptance.
- Latency: an event detected at edge t into an empty queue with an idle output shows evt_valid=1 after edge t+1 (visible during cycle t+1..t+2).
- clr_stat has priority over a same-cycle overflow/increment: the result is 0 and the drop is not counted.
- Reset mid-transfer aborts everything. No pending event survives reset.

Test Plan:
- Single report:
  - Stimulus: core 1 retires a write of r3=0xDEADBEEF, then 2 cycles later insn 0x15000002; evt_ready=1.
  - Required: one transfer with evt_core=1, code=2, value=0xDEADBEEF, evt_valid high exactly one cycle, 1-cycle latency.
- Round-robin:
  - Stimulus: all 4 cores issue putc (insn 0x15000004) in the same cycle with distinct r3 values.
  - Required: output order core 0,1,2,3 on consecutive cycles. A second simultaneous burst then starts at core 0 again, since the pointer has wrapped to 0.
- Backpressure:
  - Stimulus: evt_ready=0 for 10 cycles while core 2 issues 3 reports.
  - Required: outputs stay stable; all 3 are delivered in order after ready rises; overflow=0.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, evt_ready=0, core 0 issues 7 events.
  - Required: 1 event held in the output register plus 4 queued, 2 dropped. overflow[0]=1, drop_count=2.
  - Follow-up: clr_stat pulse returns both to 0; delivered values are the first 5 in order.
- Done detect:
  - Stimulus: cores 0..3 execute 0x15000001 at cycles 5, 9, 9, 20.
  - Required: core_done accumulates as 0001, 0111, 1111; all_done rises after the edge at cycle 20; holds through clr_stat.
- Non-events and reset:
  - Stimulus: insn 0x15000003, and 0x15000002 with trace_enable=0.
  - Required: no event for either.
  - Stimulus: assert rst while evt_valid=1.
  - Required: evt_valid, core_done and drop_count go 0 immediately (asynchronously).
